// File: rtl/base_unpack_if.sv
// Packed-beat input stream and single-item output stream of base_unpack.
// slave = unpacker view, master = producer/consumer view.
interface base_unpack_if #(
  parameter int width    = 1,
  parameter int ewidth   = 1,
  parameter int ni       = 4,
  parameter int ni_width = $clog2(ni + 1)
);
  // Both streams: a beat transfers on a rising edge where valid and ready are
  // both 1; a source holds its beat stable while valid=1 and ready=0.
  logic                  i_r;
  logic                  i_v;
  logic [ni_width-1:0]   i_nv;
  logic [ni*width-1:0]   i_d;
  logic                  i_e;
  logic [ewidth-1:0]     i_ed;
  logic                  o_r;
  logic                  o_v;
  logic [width-1:0]      o_d;
  logic                  o_e;
  logic [ewidth-1:0]     o_ed;
  logic                  o_last;

  modport slave (
    output i_r, o_v, o_d, o_e, o_ed, o_last,
    input  i_v, i_nv, i_d, i_e, i_ed, o_r
  );

  modport master (
    input  i_r, o_v, o_d, o_e, o_ed, o_last,
    output i_v, i_nv, i_d, i_e, i_ed, o_r
  );
endinterface

// File: rtl/base_unpack.sv
// Unpacks beats of up to ni items into a one-item-per-cycle stream, forwarding end markers.
// Optional macro BASE_UNPACK_BYPASS_EN: 0-cycle latency path from input when the register is empty.
module base_unpack #(
  parameter int width    = 1,
  parameter int ewidth   = 1,
  parameter int ni       = 4,
  parameter int ni_width = $clog2(ni + 1)
) (
  input  logic         clk,
  input  logic         reset,
  base_unpack_if.slave bus
);
  localparam int ptr_width = (ni > 1) ? $clog2(ni) : 1;

  logic                 r_h_v;
  logic [ni*width-1:0]  r_h_d;
  logic [ni_width-1:0]  r_h_nv;
  logic                 r_h_e;
  logic [ewidth-1:0]    r_h_ed;
  logic [ptr_width-1:0] r_h_idx;

  logic [ni_width-1:0]  w_in_nv;
  logic                 w_zero;
  logic [width-1:0]     w_reg_item;
  logic                 w_reg_last;
  logic                 w_h_done;
  logic                 w_accept;
  logic                 w_byp;
  logic                 w_pass;
  logic                 w_load;
  logic                 w_i_r;
  logic                 w_o_v;
  logic [width-1:0]     w_o_d;
  logic                 w_o_e;
  logic [ewidth-1:0]    w_o_ed;
  logic                 w_o_last;

  // Illegal counts above ni are treated as a full beat.
  assign w_in_nv = (bus.i_nv > ni_width'(ni)) ? ni_width'(ni) : bus.i_nv;
  assign w_zero  = !bus.i_e && (bus.i_nv == '0);

  always_comb begin
    w_reg_item = '0;
    for (int k = 0; k < ni; k++) begin
      if (r_h_idx == ptr_width'(k)) w_reg_item = r_h_d[k*width +: width];
    end
  end

  assign w_reg_last = r_h_e || (ni_width'(r_h_idx) == (r_h_nv - ni_width'(1)));
  assign w_h_done   = r_h_v && bus.o_r && w_reg_last;
  assign w_i_r      = !r_h_v || w_h_done;
  assign w_accept   = bus.i_v && w_i_r;

`ifdef BASE_UNPACK_BYPASS_EN
  // Empty register and a ready consumer: item 0 leaves straight from the input.
  assign w_byp = !r_h_v && bus.o_r;
`else
  assign w_byp = 1'b0;
`endif
  assign w_pass = w_byp && (bus.i_e || (w_in_nv == ni_width'(1)));
  assign w_load = w_accept && !w_zero && !w_pass;

  always_comb begin
    w_o_v    = 1'b0;
    w_o_d    = '0;
    w_o_e    = 1'b0;
    w_o_ed   = '0;
    w_o_last = 1'b0;
    if (r_h_v) begin
      w_o_v    = 1'b1;
      w_o_e    = r_h_e;
      w_o_ed   = r_h_e ? r_h_ed : '0;
      w_o_d    = r_h_e ? '0 : w_reg_item;
      w_o_last = w_reg_last;
    end
`ifdef BASE_UNPACK_BYPASS_EN
    else if (bus.i_v && !w_zero) begin
      w_o_v    = 1'b1;
      w_o_e    = bus.i_e;
      w_o_ed   = bus.i_e ? bus.i_ed : '0;
      w_o_d    = bus.i_e ? '0 : bus.i_d[width-1:0];
      w_o_last = bus.i_e || (w_in_nv == ni_width'(1));
    end
`endif
  end

  assign bus.i_r    = w_i_r;
  assign bus.o_v    = w_o_v;
  assign bus.o_d    = w_o_d;
  assign bus.o_e    = w_o_e;
  assign bus.o_ed   = w_o_ed;
  assign bus.o_last = w_o_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h_v   <= 1'b0;
      r_h_d   <= '0;
      r_h_nv  <= '0;
      r_h_e   <= 1'b0;
      r_h_ed  <= '0;
      r_h_idx <= '0;
    end else if (w_load) begin
      // A new beat may replace one finishing on this same edge.
      r_h_v   <= 1'b1;
      r_h_d   <= bus.i_d;
      r_h_nv  <= bus.i_e ? '0 : w_in_nv;
      r_h_e   <= bus.i_e;
      r_h_ed  <= bus.i_ed;
      r_h_idx <= w_byp ? ptr_width'(1) : '0;
    end else if (w_h_done) begin
      r_h_v   <= 1'b0;
      r_h_idx <= '0;
    end else if (r_h_v && bus.o_r) begin
      r_h_idx <= r_h_idx + ptr_width'(1);
    end
  end
endmodule

// File: tb/tb_base_unpack.sv
// Directed and randomized checks of base_unpack (default build) against a queue-based item model.
module tb_base_unpack;
  localparam int WD = 8;
  localparam int EW = 4;
  localparam int NI = 4;
  localparam int NW = $clog2(NI + 1);
  localparam int W  = 1 + EW + WD + 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  base_unpack_if #(.width(WD), .ewidth(EW), .ni(NI), .ni_width(NW)) bus ();

  base_unpack #(.width(WD), .ewidth(EW), .ni(NI), .ni_width(NW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: expected output beats packed as {o_e, o_ed, o_d, o_last}
  logic [W-1:0] exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic last_acc = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Item-level model: a beat expands into its items, an end beat into one marker.
  function automatic void model_beat(input logic [NW-1:0] nv, input logic [NI*WD-1:0] d,
                                     input logic e, input logic [EW-1:0] ed);
    int n;
    if (e) begin
      exp_q.push_back({1'b1, ed, {WD{1'b0}}, 1'b1});
    end else begin
      n = (int'(nv) > NI) ? NI : int'(nv);
      for (int k = 0; k < n; k++)
        exp_q.push_back({1'b0, {EW{1'b0}}, d[k*WD +: WD], 1'(k == n - 1)});
    end
  endfunction

  function automatic logic [W-1:0] obs_word();
    return {bus.o_e, bus.o_ed, bus.o_d, bus.o_last};
  endfunction

  // one cycle: sample at the falling edge, return 1 time unit after the rising edge
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clk);
    last_acc = bus.i_v && bus.i_r;
    if (last_acc) model_beat(bus.i_nv, bus.i_d, bus.i_e, bus.i_ed);
    if (bus.o_v && bus.o_r) begin
      check("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_beat", 32'(obs_word()), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int nv, input logic [NI*WD-1:0] d, input logic e,
                           input logic [EW-1:0] ed, output int nt);
    bus.i_v  = 1'b1;
    bus.i_nv = NW'(nv);
    bus.i_d  = d;
    bus.i_e  = e;
    bus.i_ed = ed;
    nt = 0;
    do begin
      tick();
      nt++;
    end while (!last_acc && nt < 20);
    check("accept", 32'(last_acc), 32'd1);
    bus.i_v = 1'b0;
  endtask

  initial begin
    int nt;
    int kind;
    bus.i_v  = 1'b0;
    bus.i_nv = '0;
    bus.i_d  = '0;
    bus.i_e  = 1'b0;
    bus.i_ed = '0;
    bus.o_r  = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_v",    32'(bus.o_v),    32'd0);
    check("rst_o_e",    32'(bus.o_e),    32'd0);
    check("rst_o_d",    32'(bus.o_d),    32'd0);
    check("rst_o_ed",   32'(bus.o_ed),   32'd0);
    check("rst_o_last", 32'(bus.o_last), 32'd0);
    check("rst_i_r",    32'(bus.i_r),    32'd1);
    reset = 1'b1;
    tick();
    tick();

    // three-item beat, consumer always ready
    bus.o_r = 1'b1;
    send_beat(3, {8'h00, 8'hCC, 8'hBB, 8'hAA}, 1'b0, 4'h0, nt);
    check("b3_lat_v",   32'(bus.o_v),    32'd1);
    check("b3_a",       32'(bus.o_d),    32'hAA);
    check("b3_a_last",  32'(bus.o_last), 32'd0);
    check("b3_a_ir",    32'(bus.i_r),    32'd0);
    tick();
    check("b3_b",       32'(bus.o_d),    32'hBB);
    check("b3_b_last",  32'(bus.o_last), 32'd0);
    tick();
    check("b3_c",       32'(bus.o_d),    32'hCC);
    check("b3_c_last",  32'(bus.o_last), 32'd1);
    check("b3_c_ir",    32'(bus.i_r),    32'd1);
    tick();
    check("b3_idle",    32'(bus.o_v),    32'd0);

    // back-to-back beats {11,22} then {33}
    send_beat(2, {8'h00, 8'h00, 8'h22, 8'h11}, 1'b0, 4'h0, nt);
    check("b2b_a", 32'(bus.o_d), 32'h11);
    send_beat(1, {8'h00, 8'h00, 8'h00, 8'h33}, 1'b0, 4'h0, nt);
    check("b2b_accept_cycle", 32'(nt), 32'd2);
    check("b2b_c",      32'(bus.o_d),    32'h33);
    check("b2b_c_last", 32'(bus.o_last), 32'd1);
    tick();
    check("b2b_idle",   32'(bus.o_v),    32'd0);

    // stall on item B for four cycles
    send_beat(4, {8'h44, 8'h43, 8'h42, 8'h41}, 1'b0, 4'h0, nt);
    tick();
    bus.o_r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall_v",    32'(bus.o_v),    32'd1);
      check("stall_d",    32'(bus.o_d),    32'h42);
      check("stall_last", 32'(bus.o_last), 32'd0);
      tick();
    end
    bus.o_r = 1'b1;
    repeat (4) tick();
    check("stall_idle",  32'(bus.o_v),        32'd0);
    check("stall_drain", 32'(exp_q.size()),   32'd0);

    // zero beat, then end marker with payload 5
    send_beat(0, {8'h99, 8'h98, 8'h97, 8'h96}, 1'b0, 4'h0, nt);
    check("zero_no_out", 32'(bus.o_v), 32'd0);
    check("zero_i_r",    32'(bus.i_r), 32'd1);
    send_beat(2, {8'h12, 8'h34, 8'h56, 8'h78}, 1'b1, 4'h5, nt);
    check("end_v",    32'(bus.o_v),    32'd1);
    check("end_e",    32'(bus.o_e),    32'd1);
    check("end_ed",   32'(bus.o_ed),   32'd5);
    check("end_last", 32'(bus.o_last), 32'd1);
    check("end_d",    32'(bus.o_d),    32'd0);
    tick();
    check("end_idle", 32'(bus.o_v), 32'd0);

    // asynchronous reset while item 2 of 4 is held
    send_beat(4, {8'hD3, 8'hD2, 8'hD1, 8'hD0}, 1'b0, 4'h0, nt);
    tick();
    tick();
    check("rst_mid_item", 32'(bus.o_d), 32'hD2);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_o_v", 32'(bus.o_v), 32'd0);
    check("rst_mid_i_r", 32'(bus.i_r), 32'd1);
    check("rst_mid_o_d", 32'(bus.o_d), 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    send_beat(1, {8'h00, 8'h00, 8'h00, 8'h5A}, 1'b0, 4'h0, nt);
    check("post_rst_x",      32'(bus.o_d),    32'h5A);
    check("post_rst_x_last", 32'(bus.o_last), 32'd1);
    tick();
    check("post_rst_idle",  32'(bus.o_v),      32'd0);
    check("post_rst_drain", 32'(exp_q.size()), 32'd0);

    // illegal count above ni is clamped to a full beat
    send_beat(7, {8'hE4, 8'hE3, 8'hE2, 8'hE1}, 1'b0, 4'h0, nt);
    repeat (5) tick();
    check("clamp_idle",  32'(bus.o_v),      32'd0);
    check("clamp_drain", 32'(exp_q.size()), 32'd0);

    // randomized traffic with random backpressure
    last_acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!bus.i_v || last_acc) begin
        bus.i_v  = ($urandom_range(0, 3) != 0);
        kind     = $urandom_range(0, 9);
        bus.i_e  = (kind == 0);
        bus.i_nv = (kind == 1) ? NW'(0) :
                   (kind == 2) ? NW'($urandom_range(5, 7)) : NW'($urandom_range(1, 4));
        bus.i_d  = $urandom;
        bus.i_ed = EW'($urandom_range(0, 15));
      end
      bus.o_r = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.i_v = 1'b0;
    bus.o_r = 1'b1;
    nt = 0;
    while ((exp_q.size() != 0 || bus.o_v) && nt < 50) begin
      tick();
      nt++;
    end
    check("rand_drain_q",  32'(exp_q.size()), 32'd0);
    check("rand_drain_ov", 32'(bus.o_v),      32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
